// File: rtl/radix4_booth_mult.sv
// ============================================================================
//  Module      : radix4_booth_mult
//  Description : Sequential signed multiplier using radix-4 Booth recoding,
//                two multiplier bits retired per falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module radix4_booth_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int HW    = WIDTH + 2;
    localparam int LW    = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [HW-1:0]      a_q;
    logic [HW-1:0]      acc_hi_q;
    logic [LW-1:0]      acc_lo_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [HW-1:0]      w_a2;
    logic [HW-1:0]      w_pp;
    logic [HW-1:0]      w_sum;
    logic [HW+LW-1:0]   w_shift;
    logic [HW-1:0]      acc_hi_d;
    logic [LW-1:0]      acc_lo_d;
    logic [2*WIDTH-1:0] product_d;

    assign w_a2 = {a_q[HW-2:0], 1'b0};

    // Partial product selected by the Booth triplet {b[i+1], b[i], b[i-1]}.
    always_comb begin
        w_pp = '0;
        case (acc_lo_q[2:0])
            3'b001, 3'b010: w_pp = a_q;
            3'b011:         w_pp = w_a2;
            3'b100:         w_pp = ~w_a2 + HW'(1);
            3'b101, 3'b110: w_pp = ~a_q + HW'(1);
            default:        w_pp = '0;
        endcase
    end

    assign w_sum     = acc_hi_q + w_pp;
    assign w_shift   = {{2{w_sum[HW-1]}}, w_sum, acc_lo_q[LW-1:2]};
    assign acc_hi_d  = w_shift[HW+LW-1:LW];
    assign acc_lo_d  = w_shift[LW-1:0];
    // acc_lo[0] holds the guard bit, so the low product half sits one bit up.
    assign product_d = {acc_hi_d[WIDTH-1:0], acc_lo_d[WIDTH:1]};

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= {{2{a[WIDTH-1]}}, a};
                        acc_hi_q <= '0;
                        acc_lo_q <= {b, 1'b0};
                        cnt_q    <= CW'(STEPS);
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        product_q <= product_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_radix4_booth_mult.sv
// ============================================================================
//  Module      : tb_radix4_booth_mult
//  Description : Scoreboard bench for radix4_booth_mult at WIDTH=16 and 8.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_radix4_booth_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done;
    logic [15:0] a, b;
    logic [31:0] product;

    logic        rst8, start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    radix4_booth_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    radix4_booth_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    int tests = 0;
    int fails = 0;
    int starts16 = 0, dones16 = 0, starts8 = 0, dones8 = 0;
    logic [31:0] q16[$];
    logic [15:0] q8[$];
    logic done_prev16 = 1'b0, done_prev8 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic, truncated to the product width.
    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[31:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[15:0];
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitors: outputs change on the falling edge, sampled on the rising edge.
    always @(posedge clk) begin
        if (done === 1'b1) begin
            dones16++;
            if (done_prev16) begin
                tests++; fails++;
                $display("FAIL done16_pulse: got done high 2 cycles required 1");
            end
            if (q16.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon16_unexpected: got done product %0h required no done", product);
            end else begin
                check("mon16_product", product, q16.pop_front());
            end
        end
        done_prev16 = (done === 1'b1);
    end

    always @(posedge clk) begin
        if (done8 === 1'b1) begin
            dones8++;
            if (done_prev8) begin
                tests++; fails++;
                $display("FAIL done8_pulse: got done high 2 cycles required 1");
            end
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL mon8_unexpected: got done product %0h required no done", product8);
            end else begin
                check("mon8_product", product8, q8.pop_front());
            end
        end
        done_prev8 = (done8 === 1'b1);
    end

    task automatic wait_idle16();
        int n = 0;
        while (busy !== 1'b0 && n <= 100) begin
            @(posedge clk);
            n++;
        end
        if (n > 100) begin
            tests++; fails++;
            $display("FAIL timeout16: got busy %b after 100 cycles required 0", busy);
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 !== 1'b0 && n <= 100) begin
            @(posedge clk);
            n++;
        end
        if (n > 100) begin
            tests++; fails++;
            $display("FAIL timeout8: got busy %b after 100 cycles required 0", busy8);
        end
    endtask

    task automatic issue16(input logic [15:0] x, input logic [15:0] y);
        wait_idle16();
        a = x; b = y; start = 1'b1;
        q16.push_back(ref16(x, y));
        starts16++;
        @(posedge clk);
        start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y);
        wait_idle8();
        a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back(ref8(x, y));
        starts8++;
        @(posedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q8.size() != 0 || busy !== 1'b0 || busy8 !== 1'b0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d/%0d pending required 0/0", q16.size(), q8.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        rst = 1'b0; rst8 = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_product", product, 32'h0);
        check("reset_product8", product8, 16'h0);

        // 3*5: cycle-accurate latency, done visible after the 8th step edge.
        a = 16'd3; b = 16'd5; start = 1'b1;
        q16.push_back(ref16(16'd3, 16'd5)); starts16++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            if (k == 1) begin
                start = 1'b0;
                check("lat_busy_k1", busy, 1'b1);
            end
            if (k == 8)  check("lat_done_k8", done, 1'b0);
            if (k == 9)  check("lat_done_k9", done, 1'b1);
            if (k == 9)  check("lat_product", product, 32'd15);
            if (k == 10) check("lat_done_k10", done, 1'b0);
            if (k == 10) check("lat_busy_k10", busy, 1'b0);
        end

        issue16(16'hFFF9, 16'd6);
        issue16(16'h7FFF, 16'h8000);
        issue16(16'h8000, 16'h8000);
        wait_idle16();
        check("min_x_min", product, 32'h4000_0000);

        // start held high with new operands mid-op: period must be STEPS+2.
        a = 16'hFFF9; b = 16'd6; start = 1'b1;
        q16.push_back(32'hFFFF_FFD6); starts16++;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            if (k == 1) begin
                a = 16'd100; b = 16'hFFFE;
                q16.push_back(ref16(16'd100, 16'hFFFE)); starts16++;
            end
            if (k == 9)  check("held_done1", done, 1'b1);
            if (k == 10) check("held_busy_low", busy, 1'b0);
            if (k == 11) begin
                start = 1'b0;
                check("held_busy_again", busy, 1'b1);
            end
            if (k == 14) check("held_product_stable", product, 32'hFFFF_FFD6);
            if (k == 18) check("held_done2_early", done, 1'b0);
            if (k == 19) check("held_done2", done, 1'b1);
        end

        // Abort during RUN: no done pulse, product cleared.
        wait_idle16();
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_product", product, 32'h0);
        issue16(16'd2, 16'd3);

        for (int i = 0; i < 3000; i++) issue16(pick16(), pick16());
        for (int i = 0; i < 3000; i++) issue8(pick8(), pick8());
        issue8(8'h80, 8'h80);
        drain();
        check("count16", dones16, starts16);
        check("count8", dones8, starts8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
